memory_io_responder: RTL and testbench
======================================

MEMORY_IO_RESPONDER -- requirements
Module: memory_io_responder

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 17, meaning the RAM holds 2^ADDR_WIDTH bytes.
REQ-002 The module SHALL have parameter FIFO_LOG, default 3, meaning the IO transmit FIFO holds 2^FIFO_LOG bytes (DEPTH).
REQ-003 Port clockIn: input, width 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port resetIn: input, width 1, reset that is synchronous and active-low.
REQ-005 Port readyIn: input, width 1, global enable for the memory side.
REQ-006 Port ramSelect: input, width 1, access type: 1 = read, 0 = write.
REQ-007 Port ramAddr: input, width 32, byte address.
REQ-008 Port ramIn: input, width 8, write data from the initiator.
REQ-009 Port ramOut: output, width 8, registered read data to the initiator.
REQ-010 Port ioBufferFull: output, width 1, IO FIFO full flag.
REQ-011 Port txData: output, width 8, FIFO head byte.
REQ-012 Port txValid: output, width 1, FIFO non-empty.
REQ-013 Port txReady: input, width 1, downstream consumes the head byte when high together with txValid.

Function
REQ-014 An access SHALL be IO when ramAddr[17:16]==2'b11 and RAM otherwise; RAM SHALL index with ramAddr[ADDR_WIDTH-1:0].
REQ-015 A RAM write SHALL occur on any cycle with readyIn=1, ramSelect=0 and a RAM address: mem[addr] <= ramIn.
REQ-016 On any cycle with readyIn=1 and ramSelect=1, ramOut SHALL load the addressed byte: a RAM byte, or an IO register value per REQ-019; the data is visible the next cycle (1-cycle read latency).
REQ-017 With readyIn=0, the block SHALL perform no RAM write, no FIFO push and no flush, and ramOut SHALL hold its value.
REQ-018 Read-during-write is not possible, since ramSelect is single; a read of an address written N cycles earlier (N≥1) SHALL return the new data.
REQ-019 IO reads SHALL have no side effects; 0x30000 SHALL return 8'h00; 0x30004 SHALL return the zero-extended FIFO count; any other IO address SHALL return 8'h00.
REQ-020 An IO write to an address with ramAddr[2:0]==0 (0x30000) SHALL push ramIn when count<DEPTH; when full the write SHALL be dropped with no state change.
REQ-021 An IO write to 0x30004 SHALL flush the FIFO: count, read pointer and write pointer all go to 0; other IO writes SHALL be ignored.
REQ-022 ioBufferFull SHALL be combinational: (count==DEPTH).
REQ-023 Push acceptance SHALL use the count from before the current cycle, so a push in a full cycle is dropped even if a pop occurs in that cycle.
REQ-024 txValid SHALL equal (count!=0), and txData SHALL equal the head entry.
REQ-025 A pop SHALL occur when txValid & txReady, independent of readyIn.
REQ-026 A simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and advance both pointers.
REQ-027 A flush and a pop in the same cycle SHALL resolve as flush only.
REQ-028 Pointers SHALL be FIFO_LOG bits wide and wrap modulo DEPTH; count SHALL be FIFO_LOG+1 bits wide, ranging 0..DEPTH.

Reset
REQ-029 On a clock edge with resetIn=0: ramOut=0, count=0, both pointers=0; consequently txValid=0 and ioBufferFull=0.
REQ-030 Reset SHALL take priority over readyIn, pushes and pops; a transfer in progress during reset SHALL be abandoned.
REQ-031 RAM contents SHALL NOT be altered by reset.

Verification
REQ-032 Scenario: write 0xA5 to 0x00010 with readyIn=1, then read 0x00010 -> ramOut=0xA5 one cycle after the read address is presented.
REQ-033 Scenario: readyIn=0 with a write of 0x5A to 0x00010 -> mem unchanged, and ramOut holds its prior value.
REQ-034 Scenario: txReady=0, 9 writes of 0x01..0x09 to 0x30000 (DEPTH=8) -> ioBufferFull=1 after the 8th write, the 9th write is dropped, and a read of 0x30004 returns 0x08.
REQ-035 Scenario: with the FIFO full, raise txReady for 1 cycle while pushing 0x09 -> 0x01 is popped, the push is dropped, count=7, and ioBufferFull=0 the following cycle.
REQ-036 Scenario: count=3 with txReady=1 and a push every cycle -> count stays 3 and the output order is preserved across pointer wrap.
REQ-037 Scenario: count=5, then a flush write to 0x30004 with txReady=1 -> count=0 and txValid=0 next cycle; then assert resetIn=0 mid-stream -> all outputs 0 and RAM byte 0x00010 still reads 0xA5.

Source files
------------

// File: rtl/memory_io_responder.sv
// Byte-wide memory responder. Addresses with bits [17:16] == 2'b11 reach a
// small IO window: a transmit FIFO push register and a count/flush register.
// All other addresses reach a byte RAM that has a one-cycle registered read.
module memory_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_LOG   = 3
) (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        readyIn,
  input  logic        ramSelect,
  input  logic [31:0] ramAddr,
  input  logic [7:0]  ramIn,
  output logic [7:0]  ramOut,
  output logic        ioBufferFull,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady
);

  localparam int DEPTH = 1 << FIFO_LOG;
  localparam logic [FIFO_LOG:0]   FULL_COUNT = (FIFO_LOG + 1)'(DEPTH);
  localparam logic [FIFO_LOG:0]   COUNT_ONE  = (FIFO_LOG + 1)'(1);
  localparam logic [FIFO_LOG-1:0] PTR_ONE    = FIFO_LOG'(1);

  // IO register offsets, decoded from the low three address bits.
  localparam logic [2:0] IO_DATA_OFS  = 3'b000;
  localparam logic [2:0] IO_COUNT_OFS = 3'b100;

  logic [7:0] mem [2**ADDR_WIDTH];
  logic [7:0] fifoMem [DEPTH];

  logic [FIFO_LOG-1:0] rdPtr;
  logic [FIFO_LOG-1:0] wrPtr;
  logic [FIFO_LOG:0]   count;

  logic [ADDR_WIDTH-1:0] ramIndex;
  logic                  isIo;
  logic                  ioWrite;
  logic                  ramWrite;
  logic                  ioPush;
  logic                  ioFlush;
  logic                  pop;
  logic [7:0]            ioReadData;
  logic                  unusedAddrBits;

  assign ramIndex = ramAddr[ADDR_WIDTH-1:0];
  assign isIo     = (ramAddr[17:16] == 2'b11);
  assign ramWrite = readyIn & ~ramSelect & ~isIo;
  assign ioWrite  = readyIn & ~ramSelect & isIo;

  // Push acceptance looks only at the registered count, so a pop in the same
  // cycle cannot open room for a push into a full FIFO.
  assign ioPush  = ioWrite & (ramAddr[2:0] == IO_DATA_OFS) & ~ioBufferFull;
  assign ioFlush = ioWrite & (ramAddr[2:0] == IO_COUNT_OFS);
  assign pop     = txValid & txReady;

  assign ioBufferFull = (count == FULL_COUNT);
  assign txValid      = (count != '0);
  assign txData       = fifoMem[rdPtr];

  // IO reads are side-effect free; only the count register returns data.
  assign ioReadData = (ramAddr[2:0] == IO_COUNT_OFS) ? 8'(count) : 8'h00;

  // Upper address bits play no part in decoding.
  assign unusedAddrBits = ^ramAddr[31:18];

  // RAM byte write; reset suppresses it but never clears the array.
  // NOTE: storage arrays carry no reset so they map onto plain RAM; state that
  // must be known after reset lives in the control registers only.
  always_ff @(posedge clockIn) begin
    if (resetIn && ramWrite) begin
      mem[ramIndex] <= ramIn;
    end
  end

  // FIFO entry write at the write pointer on an accepted push.
  always_ff @(posedge clockIn) begin
    if (resetIn && ioPush) begin
      fifoMem[wrPtr] <= ramIn;
    end
  end

  // Registered read data: RAM byte or IO register, held while readyIn is low.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      ramOut <= 8'h00;
    end else if (readyIn && ramSelect) begin
      ramOut <= isIo ? ioReadData : mem[ramIndex];
    end
  end

  // FIFO pointers and occupancy; flush overrides a same-cycle pop.
  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (ioFlush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (ioPush) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      if (ioPush && !pop) begin
        count <= count + COUNT_ONE;
      end else if (!ioPush && pop) begin
        count <= count - COUNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_memory_io_responder.sv
// Bench for memory_io_responder: directed scenarios followed by randomized
// traffic, all compared against a queue/associative-array reference model.
module tb_memory_io_responder;

  localparam int DEPTH = 8;
  localparam logic [31:0] IO_DATA  = 32'h0003_0000;
  localparam logic [31:0] IO_COUNT = 32'h0003_0004;
  localparam logic [31:0] IO_OTHER = 32'h0003_0002;

  logic        clockIn = 1'b0;
  logic        resetIn;
  logic        readyIn;
  logic        ramSelect;
  logic [31:0] ramAddr;
  logic [7:0]  ramIn;
  logic [7:0]  ramOut;
  logic        ioBufferFull;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;

  always #5 clockIn = ~clockIn;

  memory_io_responder dut (
    .clockIn      (clockIn),
    .resetIn      (resetIn),
    .readyIn      (readyIn),
    .ramSelect    (ramSelect),
    .ramAddr      (ramAddr),
    .ramIn        (ramIn),
    .ramOut       (ramOut),
    .ioBufferFull (ioBufferFull),
    .txData       (txData),
    .txValid      (txValid),
    .txReady      (txReady)
  );

  // Reference model state.
  byte unsigned ramModel [int];
  byte unsigned fifoQ [$];
  logic [7:0]   expRamOut = 8'h00;
  bit           expKnown  = 1'b1;

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] ramPool [8] = '{32'h0_0000, 32'h0_0010, 32'h0_FFFF, 32'h1_FFFF,
                               32'h1_2345, 32'h2_0010, 32'h2_ABCD, 32'h0_0100};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic rdy, input logic sel, input logic [31:0] addr,
                       input logic [7:0] data, input logic txr);
    readyIn   = rdy;
    ramSelect = sel;
    ramAddr   = addr;
    ramIn     = data;
    txReady   = txr;
  endtask

  // Apply the documented behaviour for one rising edge to the model.
  task automatic modelEdge();
    bit io, popNow, pushOk, flush;
    int idx;
    if (!resetIn) begin
      expRamOut = 8'h00;
      expKnown  = 1'b1;
      fifoQ.delete();
      return;
    end
    io     = (ramAddr[17:16] == 2'b11);
    idx    = int'(ramAddr[16:0]);
    popNow = (fifoQ.size() != 0) && txReady;
    flush  = readyIn && !ramSelect && (ramAddr == IO_COUNT);
    pushOk = readyIn && !ramSelect && (ramAddr == IO_DATA) && (fifoQ.size() < DEPTH);
    if (readyIn && ramSelect) begin
      if (io) begin
        expRamOut = (ramAddr == IO_COUNT) ? 8'(fifoQ.size()) : 8'h00;
        expKnown  = 1'b1;
      end else if (ramModel.exists(idx)) begin
        expRamOut = ramModel[idx];
        expKnown  = 1'b1;
      end else begin
        expKnown  = 1'b0;
      end
    end
    if (readyIn && !ramSelect && !io) ramModel[idx] = ramIn;
    if (flush) begin
      fifoQ.delete();
    end else begin
      if (popNow) void'(fifoQ.pop_front());
      if (pushOk) fifoQ.push_back(ramIn);
    end
  endtask

  task automatic checkOutputs();
    if (expKnown) check("ramOut", ramOut, expRamOut);
    check("txValid", txValid, fifoQ.size() != 0);
    check("ioBufferFull", ioBufferFull, fifoQ.size() == DEPTH);
    if (fifoQ.size() != 0) check("txData", txData, fifoQ[0]);
  endtask

  // One clock: model follows the edge, outputs are compared 1 ns later.
  task automatic tick();
    @(posedge clockIn);
    modelEdge();
    #1;
    checkOutputs();
  endtask

  initial begin
    resetIn = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
    tick();
    tick();
    check("rst_ramOut", ramOut, 32'h0);
    check("rst_txValid", txValid, 32'h0);
    check("rst_full", ioBufferFull, 32'h0);
    resetIn = 1'b1;

    // Write then read back a RAM byte.
    drive(1'b1, 1'b0, 32'h10, 8'hA5, 1'b0); tick();
    drive(1'b1, 1'b1, 32'h10, 8'h00, 1'b0); tick();
    check("s_read_a5", ramOut, 32'hA5);

    // readyIn low: no write, ramOut holds.
    drive(1'b0, 1'b0, 32'h10, 8'h5A, 1'b0); tick();
    check("s_hold", ramOut, 32'hA5);
    drive(1'b0, 1'b1, 32'h0, 8'h00, 1'b0); tick();
    check("s_hold_read", ramOut, 32'hA5);
    drive(1'b1, 1'b1, 32'h10, 8'h00, 1'b0); tick();
    check("s_mem_kept", ramOut, 32'hA5);

    // Fill the FIFO; the ninth push is dropped.
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 1'b0, IO_DATA, 8'(i), 1'b0); tick();
      if (i == 7) check("s_full_7", ioBufferFull, 32'h0);
      if (i == 8) check("s_full_8", ioBufferFull, 32'h1);
    end
    check("s_head_1", txData, 32'h01);
    drive(1'b1, 1'b1, IO_COUNT, 8'h00, 1'b0); tick();
    check("s_count_8", ramOut, 32'h08);

    // Full FIFO: pop and push together, push dropped.
    drive(1'b1, 1'b0, IO_DATA, 8'h09, 1'b1); tick();
    check("s_full_pop", ioBufferFull, 32'h0);
    check("s_head_2", txData, 32'h02);
    drive(1'b1, 1'b1, IO_COUNT, 8'h00, 1'b0); tick();
    check("s_count_7", ramOut, 32'h07);

    // Drain to 3, then push and pop every cycle across pointer wrap.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'h0, 8'h00, 1'b1); tick();
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, IO_DATA, 8'(8'h40 + i), 1'b1); tick();
    end
    drive(1'b1, 1'b1, IO_COUNT, 8'h00, 1'b0); tick();
    check("s_count_3", ramOut, 32'h03);
    check("s_head_wrap", txData, 32'h49);

    // Grow to 5, flush with txReady high.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, IO_DATA, 8'(8'h60 + i), 1'b0); tick();
    end
    drive(1'b1, 1'b1, IO_COUNT, 8'h00, 1'b0); tick();
    check("s_count_5", ramOut, 32'h05);
    drive(1'b1, 1'b0, IO_COUNT, 8'h00, 1'b1); tick();
    check("s_flush_valid", txValid, 32'h0);
    drive(1'b1, 1'b1, IO_COUNT, 8'h00, 1'b0); tick();
    check("s_flush_count", ramOut, 32'h00);

    // Reset mid-stream: outputs clear, RAM survives.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, IO_DATA, 8'(8'h70 + i), 1'b0); tick();
    end
    drive(1'b1, 1'b1, 32'h10, 8'h00, 1'b0); tick();
    resetIn = 1'b0;
    drive(1'b1, 1'b0, IO_DATA, 8'h77, 1'b1); tick();
    check("s_rst_ramOut", ramOut, 32'h0);
    check("s_rst_valid", txValid, 32'h0);
    check("s_rst_full", ioBufferFull, 32'h0);
    resetIn = 1'b1;
    drive(1'b1, 1'b1, 32'h10, 8'h00, 1'b0); tick();
    check("s_ram_after_rst", ramOut, 32'hA5);

    // Preload the RAM pool so every random read has a known value.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, ramPool[i], 8'($urandom), 1'b0); tick();
    end

    // Randomized mixed traffic.
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] addr;
      int r;
      resetIn = ($urandom_range(0, 99) != 0);
      r = $urandom_range(0, 19);
      if (r < 8)       addr = ramPool[$urandom_range(0, 7)];
      else if (r < 16) addr = IO_DATA;
      else if (r < 18) addr = IO_COUNT;
      else             addr = IO_OTHER;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, addr,
            8'($urandom), $urandom_range(0, 2) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
